// File: rtl/rbt_s_transport_opt_tlv_parser.sv
// rtl/rbt_s_transport_opt_tlv_parser.sv - SEADP/SEAUP/SEASP TLV option walker setting DAT/XTRANS/RFLAG/OPT_ERR
module rbt_s_transport_opt_tlv_parser #(
  parameter int          HEADER_WIDTH       = 2048,
  parameter int          PKT_METADATA_WIDTH = 272,
  parameter int          PROTO_NO           = 40,
  parameter int          PKT_PROPERTY_NO    = 246,
  parameter int          OPT_OFFSET         = 5,
  parameter int          MAX_OPTS           = 8,
  parameter logic [7:0]  RFLAG_TYPE         = 8'h80,
  localparam int         CW                 = $clog2(MAX_OPTS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_proto_hdr_valid,
  output logic                          in_proto_hdr_ready,
  input  logic [15:0]                   in_proto_hdr_length,
  input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
  input  logic [PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
  output logic                          out_proto_hdr_valid,
  input  logic                          out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
  output logic [15:0]                   out_proto_hdr_length,
  output logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata,
  output logic [CW-1:0]                 out_opt_count
);

  localparam int NB          = HEADER_WIDTH / 8;
  localparam int TAG_SEADP   = PROTO_NO + 12;
  localparam int TAG_SEAUP   = PROTO_NO + 13;
  localparam int TAG_SEASP   = PROTO_NO + 14;
  localparam int PROP_DAT    = PKT_PROPERTY_NO + 0;
  localparam int PROP_XTRANS = PKT_PROPERTY_NO + 6;
  localparam int PROP_RFLAG  = PKT_PROPERTY_NO + 7;
  localparam int PROP_OPTERR = PKT_PROPERTY_NO + 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_OUT
  } state_t;

  state_t                          state_q, state_d;
  logic [HEADER_WIDTH-1:0]         data_q, data_d;
  logic [15:0]                     len_q, len_d;
  logic [PKT_METADATA_WIDTH-1:0]   meta_q, meta_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [16:0]                     cursor_q, cursor_d;

  // Scan bound: declared length clipped to what the header bus actually carries.
  logic [16:0] limit;
  assign limit = ({1'b0, len_q} < 17'(NB)) ? {1'b0, len_q} : 17'(NB);

  // Bring the byte under the cursor to the top of the bus; beyond the bus it reads as zero,
  // but those values are only consulted when the cursor is inside the limit.
  logic [HEADER_WIDTH-1:0] shifted;
  logic [7:0]              opt_type;
  logic [7:0]              opt_len;
  assign shifted  = data_q << {cursor_q, 3'b000};
  assign opt_type = shifted[HEADER_WIDTH-1 -: 8];
  assign opt_len  = shifted[HEADER_WIDTH-9 -: 8];

  logic [16:0]   cur_p1;
  logic [16:0]   cur_pl;
  logic [CW-1:0] count_p1;
  assign cur_p1   = cursor_q + 17'd1;
  assign cur_pl   = cursor_q + {9'd0, opt_len};
  assign count_p1 = count_q + CW'(1);

  logic trigger;
  assign trigger = (in_proto_hdr_pkt_metadata[TAG_SEADP] |
                    in_proto_hdr_pkt_metadata[TAG_SEAUP] |
                    in_proto_hdr_pkt_metadata[TAG_SEASP]) &
                   in_proto_hdr_data[HEADER_WIDTH-25];

  // State and datapath registers; reset drops any in-flight header.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      len_q    <= '0;
      meta_q   <= '0;
      count_q  <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      len_q    <= len_d;
      meta_q   <= meta_d;
      count_q  <= count_d;
      cursor_q <= cursor_d;
    end
  end

  // Next-state: accept in IDLE, walk one option per cycle in SCAN, hold in OUT until taken.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    meta_d   = meta_q;
    count_d  = count_q;
    cursor_d = cursor_q;
    case (state_q)
      S_IDLE: begin
        if (in_proto_hdr_valid) begin
          data_d   = in_proto_hdr_data;
          len_d    = in_proto_hdr_length;
          meta_d   = in_proto_hdr_pkt_metadata;
          count_d  = '0;
          cursor_d = '0;
          if (trigger) begin
            meta_d[PROP_DAT]    = 1'b1;
            meta_d[PROP_XTRANS] = 1'b1;
            cursor_d            = 17'(OPT_OFFSET);
            state_d             = S_SCAN;
          end else begin
            state_d = S_OUT;
          end
        end
      end
      S_SCAN: begin
        if (cursor_q >= limit) begin
          state_d = S_OUT;
        end else if (opt_type == 8'h00) begin
          state_d = S_OUT;
        end else if (opt_type == 8'h01) begin
          cursor_d = cur_p1;
        end else if ((cur_p1 >= limit) || (opt_len < 8'd2) || (cur_pl > limit)) begin
          // Option header or body runs past the limit: flag it and stop walking.
          meta_d[PROP_OPTERR] = 1'b1;
          state_d             = S_OUT;
        end else begin
          if (opt_type == RFLAG_TYPE) begin
            meta_d[PROP_RFLAG] = 1'b1;
          end
          count_d  = count_p1;
          cursor_d = cur_pl;
          if (count_p1 == CW'(MAX_OPTS)) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_proto_hdr_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_proto_hdr_ready         = (state_q == S_IDLE);
  assign out_proto_hdr_valid        = (state_q == S_OUT);
  assign out_proto_hdr_data         = data_q;
  assign out_proto_hdr_length       = len_q;
  assign out_proto_hdr_pkt_metadata = meta_q;
  assign out_opt_count              = count_q;

endmodule

// File: tb/tb_rbt_s_transport_opt_tlv_parser.sv
// tb/tb_rbt_s_transport_opt_tlv_parser.sv - directed plus randomized bench against a TLV reference model
module tb_rbt_s_transport_opt_tlv_parser;

  localparam int HW       = 2048;
  localparam int PMW      = 272;
  localparam int PROTO_NO = 40;
  localparam int PP       = 246;
  localparam int NB       = HW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic [15:0]     in_len   = '0;
  logic [HW-1:0]   in_data  = '0;
  logic [PMW-1:0]  in_meta  = '0;
  logic            out_ready = 1'b1;

  logic            in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [HW-1:0]   out_data_a, out_data_b;
  logic [15:0]     out_len_a, out_len_b;
  logic [PMW-1:0]  out_meta_a, out_meta_b;
  logic [3:0]      out_cnt_a;
  logic [1:0]      out_cnt_b;

  rbt_s_transport_opt_tlv_parser dut_a (
    .clk(clk), .rst(rst),
    .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready_a),
    .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data),
    .in_proto_hdr_pkt_metadata(in_meta),
    .out_proto_hdr_valid(out_valid_a), .out_proto_hdr_ready(out_ready),
    .out_proto_hdr_data(out_data_a), .out_proto_hdr_length(out_len_a),
    .out_proto_hdr_pkt_metadata(out_meta_a), .out_opt_count(out_cnt_a)
  );

  rbt_s_transport_opt_tlv_parser #(.MAX_OPTS(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready_b),
    .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data),
    .in_proto_hdr_pkt_metadata(in_meta),
    .out_proto_hdr_valid(out_valid_b), .out_proto_hdr_ready(out_ready),
    .out_proto_hdr_data(out_data_b), .out_proto_hdr_length(out_len_b),
    .out_proto_hdr_pkt_metadata(out_meta_b), .out_opt_count(out_cnt_b)
  );

  int tests = 0;
  int fails = 0;

  logic [HW-1:0]  hdr;
  logic [15:0]    hlen;
  logic [PMW-1:0] hmeta;
  logic [PMW-1:0] obs_meta_a;
  int             obs_cnt_a, obs_lat_a;

  task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs[299:0], exp[299:0]);
    end
  endtask

  task automatic put(input int i, input logic [7:0] v);
    if (i < NB) hdr[HW-1-8*i -: 8] = v;
  endtask

  function automatic int byte_at(input logic [HW-1:0] d, input int i);
    return int'(d[HW-1-8*i -: 8]);
  endfunction

  // Reference: walk the option list as a byte array, counting cycles spent scanning.
  task automatic model(input logic [HW-1:0] d, input int len, input logic [PMW-1:0] m,
                       input int max_opts, output logic [PMW-1:0] om, output int cnt, output int lat);
    int lim, cur, b, l, scans;
    om = m; cnt = 0; lat = 1;
    if (!((m[PROTO_NO+12] || m[PROTO_NO+13] || m[PROTO_NO+14]) && d[HW-25])) return;
    om[PP+0] = 1'b1;
    om[PP+6] = 1'b1;
    lim = (len < NB) ? len : NB;
    cur = 5;
    scans = 0;
    while (1) begin
      scans++;
      if (cur >= lim) break;
      b = byte_at(d, cur);
      if (b == 0) break;
      if (b == 1) begin cur++; continue; end
      l = (cur + 1 < lim) ? byte_at(d, cur + 1) : 0;
      if (cur + 1 >= lim || l < 2 || cur + l > lim) begin om[PP+8] = 1'b1; break; end
      if (b == 8'h80) om[PP+7] = 1'b1;
      cnt++;
      cur += l;
      if (cnt == max_opts) break;
    end
    lat = scans + 1;
  endtask

  task automatic run_txn(input string tag);
    logic [PMW-1:0] em_a, em_b;
    int ec_a, ec_b, el_a, el_b, cyc;
    bit got_a, got_b;
    model(hdr, int'(hlen), hmeta, 8, em_a, ec_a, el_a);
    model(hdr, int'(hlen), hmeta, 2, em_b, ec_b, el_b);
    out_ready = 1'b1;
    check({tag, "/in_ready"}, {in_ready_b, in_ready_a}, 2'b11);
    in_data = hdr; in_len = hlen; in_meta = hmeta; in_valid = 1'b1;
    @(posedge clk);
    got_a = 0; got_b = 0; cyc = 0;
    while (!(got_a && got_b) && cyc < 400) begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      if (!got_a && out_valid_a) begin
        got_a = 1;
        check({tag, "/a_meta"}, out_meta_a, em_a);
        check({tag, "/a_count"}, out_cnt_a, ec_a);
        check({tag, "/a_data"}, out_data_a, hdr);
        check({tag, "/a_len"}, out_len_a, hlen);
        check({tag, "/a_latency"}, cyc, el_a);
        obs_meta_a = out_meta_a; obs_cnt_a = int'(out_cnt_a); obs_lat_a = cyc;
      end
      if (!got_b && out_valid_b) begin
        got_b = 1;
        check({tag, "/b_meta"}, out_meta_b, em_b);
        check({tag, "/b_count"}, out_cnt_b, ec_b);
        check({tag, "/b_latency"}, cyc, el_b);
      end
    end
    if (!got_a) check({tag, "/a_timeout"}, 0, 1);
    if (!got_b) check({tag, "/b_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic base_hdr(input int tag_sel);
    for (int i = 0; i < HW / 32; i++) hdr[32*i +: 32] = $urandom;
    hmeta = '0;
    if (tag_sel < 3) hmeta[PROTO_NO + 12 + tag_sel] = 1'b1;
    hdr[HW-25] = 1'b1;
    hlen = 16'd40;
  endtask

  task automatic gen_rand();
    logic [287:0] t;
    int pos, k, l;
    for (int i = 0; i < HW / 32; i++) hdr[32*i +: 32] = $urandom;
    for (int i = 0; i < 9; i++) t[32*i +: 32] = $urandom;
    hmeta = t[PMW-1:0];
    if ($urandom_range(0, 3) != 0) for (int i = 0; i < 9; i++) hmeta[PP+i] = 1'b0;
    for (int i = 12; i < 15; i++) hmeta[PROTO_NO+i] = 1'b0;
    k = $urandom_range(0, 3);
    if (k < 3) hmeta[PROTO_NO + 12 + k] = 1'b1;
    hdr[HW-25] = ($urandom_range(0, 5) != 0);
    pos = 5;
    while (pos < 60) begin
      k = $urandom_range(0, 19);
      if (k < 3) begin put(pos, 8'h01); pos++; end
      else if (k == 3) begin put(pos, 8'h00); pos++; end
      else if (k == 4) begin put(pos, 8'h33); put(pos + 1, 8'($urandom_range(0, 1))); pos += 2; end
      else begin
        put(pos, (k == 5) ? 8'h80 : 8'($urandom_range(2, 255)));
        l = $urandom_range(2, 7);
        put(pos + 1, 8'(l));
        pos += l;
      end
    end
    k = $urandom_range(0, 9);
    hlen = (k == 0) ? 16'd300 : (k == 1) ? 16'($urandom_range(0, 6)) : 16'($urandom_range(8, 64));
  endtask

  initial begin
    logic [PMW-1:0] em;
    int ec, el;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset/in_ready", in_ready_a, 1'b1);
    check("reset/out_valid", out_valid_a, 1'b0);
    check("reset/meta", out_meta_a, '0);
    check("reset/data", out_data_a, '0);
    check("reset/len", out_len_a, '0);
    check("reset/count", out_cnt_a, '0);

    // T1: no SEA* tag, fast path with random metadata
    base_hdr(3);
    for (int i = 0; i < 8; i++) hmeta[32*i +: 32] = $urandom;
    for (int i = 12; i < 15; i++) hmeta[PROTO_NO+i] = 1'b0;
    run_txn("T1");
    check("T1/latency_const", obs_lat_a, 1);
    check("T1/meta_const", obs_meta_a, hmeta);
    check("T1/count_const", obs_cnt_a, 0);

    // T2: SEADP, [80 02][00]
    base_hdr(0);
    put(5, 8'h80); put(6, 8'h02); put(7, 8'h00);
    run_txn("T2");
    check("T2/props_const", {obs_meta_a[PP+8], obs_meta_a[PP+7], obs_meta_a[PP+6], obs_meta_a[PP+0]}, 4'b0111);
    check("T2/count_const", obs_cnt_a, 1);
    check("T2/latency_const", obs_lat_a, 3);

    // T3: SEAUP, [01][01][05 04 aa bb][00]
    base_hdr(1);
    put(5, 8'h01); put(6, 8'h01); put(7, 8'h05); put(8, 8'h04);
    put(9, 8'haa); put(10, 8'hbb); put(11, 8'h00);
    run_txn("T3");
    check("T3/rflag_const", obs_meta_a[PP+7], 1'b0);
    check("T3/count_const", obs_cnt_a, 1);
    check("T3/latency_const", obs_lat_a, 5);

    // T4: SEASP, option overruns len=12, then length below 2
    base_hdr(2);
    hlen = 16'd12;
    put(5, 8'h07); put(6, 8'h09);
    run_txn("T4a");
    check("T4a/opterr_const", obs_meta_a[PP+8], 1'b1);
    check("T4a/count_const", obs_cnt_a, 0);
    put(6, 8'h01);
    run_txn("T4b");
    check("T4b/opterr_const", obs_meta_a[PP+8], 1'b1);

    // T5: three options; the MAX_OPTS=2 instance stops after two
    base_hdr(0);
    put(5, 8'h10); put(6, 8'h02); put(7, 8'h11); put(8, 8'h02);
    put(9, 8'h80); put(10, 8'h02); put(11, 8'h00);
    run_txn("T5");
    check("T5/a_count_const", obs_cnt_a, 3);

    // T6: downstream stall holds outputs, then back-to-back accept
    base_hdr(3);
    model(hdr, int'(hlen), hmeta, 8, em, ec, el);
    out_ready = 1'b0;
    in_data = hdr; in_len = hlen; in_meta = hmeta; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("T6/stall_valid", out_valid_a, 1'b1);
      check("T6/stall_in_ready", in_ready_a, 1'b0);
      check("T6/stall_meta", out_meta_a, em);
      check("T6/stall_data", out_data_a, hdr);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("T6/post_hs_in_ready", in_ready_a, 1'b1);
    check("T6/post_hs_valid", out_valid_a, 1'b0);
    base_hdr(1);
    put(5, 8'h80); put(6, 8'h03); put(8, 8'h00);
    run_txn("T6b");

    // Reset during SCAN drops the header
    base_hdr(0);
    hlen = 16'd100;
    for (int i = 5; i < 80; i++) put(i, 8'h01);
    in_data = hdr; in_len = hlen; in_meta = hmeta; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scan/busy", in_ready_a, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_scan/out_valid", out_valid_a, 1'b0);
    check("rst_scan/in_ready", in_ready_a, 1'b1);
    check("rst_scan/meta", out_meta_a, '0);
    check("rst_scan/count", out_cnt_a, '0);
    repeat (3) @(negedge clk);
    check("rst_scan/still_idle", out_valid_a, 1'b0);

    for (int n = 0; n < 60; n++) begin
      gen_rand();
      run_txn($sformatf("R%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
